// File: rtl/regfile_writeback_ctrl.sv
// Register-file write arbiter: ALU results and buffered MUL/DIV results share one write port, with a busy scoreboard driving STALL.
// Writes land 1 cycle after selection. MD_READY drops only when the FIFO is full; ALU_HOLD makes the ALU re-present its result while the FIFO drains.
module regfile_writeback_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  ALU_VALID,
    input  logic [ADDR_WIDTH-1:0] ALU_RD,
    input  logic [DATA_WIDTH-1:0] ALU_DATA,
    input  logic                  MD_VALID,
    input  logic [ADDR_WIDTH-1:0] MD_RD,
    input  logic [DATA_WIDTH-1:0] MD_DATA,
    output logic                  MD_READY,
    input  logic                  ISSUE_VALID,
    input  logic [ADDR_WIDTH-1:0] ISSUE_RD,
    input  logic [ADDR_WIDTH-1:0] CHK_RS1,
    input  logic [ADDR_WIDTH-1:0] CHK_RS2,
    input  logic [ADDR_WIDTH-1:0] CHK_RD,
    output logic                  STALL,
    output logic                  ALU_HOLD,
    output logic [ADDR_WIDTH-1:0] WB_ADDRESS,
    output logic                  WRITE_ENABLE,
    output logic [DATA_WIDTH-1:0] WRITE_DATA,
    output logic [31:0]           BUSY_MASK
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] r_fifo_rd   [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [CW-1:0]         r_count;
    logic [31:0]           r_busy;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_alu_req;
    logic                  w_alu_wr;
    logic                  w_fifo_wr;
    logic                  w_enq;
    logic [ADDR_WIDTH-1:0] w_head_rd;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [31:0]           w_busy_nxt;

    assign w_full      = (r_count == FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_alu_req   = ALU_VALID && (ALU_RD != '0);
    assign w_alu_wr    = w_alu_req && !w_full;
    // A full FIFO always drains, otherwise it only uses cycles the ALU leaves free.
    assign w_fifo_wr   = !w_empty && (w_full || !w_alu_req);
    assign w_head_rd   = r_fifo_rd[r_rptr];
    assign w_head_data = r_fifo_data[r_rptr];

    assign MD_READY  = !RESET && !w_full;
    assign w_enq     = MD_VALID && MD_READY && (MD_RD != '0);
    assign ALU_HOLD  = ALU_VALID && w_full;
    assign BUSY_MASK = r_busy;
    assign STALL     = ALU_HOLD | r_busy[CHK_RS1] | r_busy[CHK_RS2] | r_busy[CHK_RD];

    // Clear before set so a same-edge reissue of the retiring rd keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_fifo_wr)
            w_busy_nxt[w_head_rd] = 1'b0;
        if (ISSUE_VALID)
            w_busy_nxt[ISSUE_RD] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge CLK) begin
        if (w_enq) begin
            r_fifo_rd[r_wptr]   <= MD_RD;
            r_fifo_data[r_wptr] <= MD_DATA;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_busy  <= '0;
        end else begin
            if (w_enq)
                r_wptr <= r_wptr + PW'(1);
            if (w_fifo_wr)
                r_rptr <= r_rptr + PW'(1);
            case ({w_enq, w_fifo_wr})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            r_busy <= w_busy_nxt;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            WB_ADDRESS   <= '0;
            WRITE_DATA   <= '0;
            WRITE_ENABLE <= 1'b0;
        end else begin
            WRITE_ENABLE <= w_alu_wr || w_fifo_wr;
            if (w_fifo_wr) begin
                WB_ADDRESS <= w_head_rd;
                WRITE_DATA <= w_head_data;
            end else if (w_alu_wr) begin
                WB_ADDRESS <= ALU_RD;
                WRITE_DATA <= ALU_DATA;
            end
        end
    end
endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// Directed table of per-cycle inputs and expected outputs, plus a hand-written reset-mid-drain sequence.
module tb_regfile_writeback_ctrl;
    logic        CLK = 1'b0;
    logic        RESET;
    logic        ALU_VALID, MD_VALID, ISSUE_VALID;
    logic [4:0]  ALU_RD, MD_RD, ISSUE_RD, CHK_RS1, CHK_RS2, CHK_RD;
    logic [31:0] ALU_DATA, MD_DATA;
    logic        MD_READY, STALL, ALU_HOLD, WRITE_ENABLE;
    logic [4:0]  WB_ADDRESS;
    logic [31:0] WRITE_DATA, BUSY_MASK;

    int tests  = 0;
    int failed = 0;

    always #5 CLK = ~CLK;

    regfile_writeback_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIFO_DEPTH(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
        .MD_VALID(MD_VALID), .MD_RD(MD_RD), .MD_DATA(MD_DATA), .MD_READY(MD_READY),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD),
        .CHK_RS1(CHK_RS1), .CHK_RS2(CHK_RS2), .CHK_RD(CHK_RD),
        .STALL(STALL), .ALU_HOLD(ALU_HOLD),
        .WB_ADDRESS(WB_ADDRESS), .WRITE_ENABLE(WRITE_ENABLE), .WRITE_DATA(WRITE_DATA),
        .BUSY_MASK(BUSY_MASK)
    );

    // Each row: inputs driven for one cycle, and the outputs seen during that cycle
    // (registered outputs reflect the previous row's edge).
    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] ad;
        logic        mv;  logic [4:0] mrd; logic [31:0] md;
        logic        iv;  logic [4:0] ird;
        logic [4:0]  c1, c2, cd;
        logic        ewe; logic [4:0] ea;  logic [31:0] ed;
        logic [31:0] eb;
        logic        er, es, eh;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    function automatic vec_t mk(
        input logic av, input logic [4:0] ard, input logic [31:0] ad,
        input logic mv, input logic [4:0] mrd, input logic [31:0] md,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] c1, input logic [4:0] c2, input logic [4:0] cd,
        input logic ewe, input logic [4:0] ea, input logic [31:0] ed,
        input logic [31:0] eb, input logic er, input logic es, input logic eh);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad;
        v.mv = mv; v.mrd = mrd; v.md = md;
        v.iv = iv; v.ird = ird;
        v.c1 = c1; v.c2 = c2; v.cd = cd;
        v.ewe = ewe; v.ea = ea; v.ed = ed; v.eb = eb;
        v.er = er; v.es = es; v.eh = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ALU_VALID = v.av; ALU_RD = v.ard; ALU_DATA = v.ad;
        MD_VALID = v.mv; MD_RD = v.mrd; MD_DATA = v.md;
        ISSUE_VALID = v.iv; ISSUE_RD = v.ird;
        CHK_RS1 = v.c1; CHK_RS2 = v.c2; CHK_RD = v.cd;
    endtask

    task automatic idle();
        drive(mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 0, 0,0,0));
    endtask

    task automatic check_row(input string tag, input vec_t v);
        check({tag, " we"},    {31'd0, WRITE_ENABLE}, {31'd0, v.ewe});
        check({tag, " addr"},  {27'd0, WB_ADDRESS},   {27'd0, v.ea});
        check({tag, " data"},  WRITE_DATA,            v.ed);
        check({tag, " busy"},  BUSY_MASK,             v.eb);
        check({tag, " ready"}, {31'd0, MD_READY},     {31'd0, v.er});
        check({tag, " stall"}, {31'd0, STALL},        {31'd0, v.es});
        check({tag, " hold"},  {31'd0, ALU_HOLD},     {31'd0, v.eh});
    endtask

    initial begin
        //            alu              md                 issue  chk        we addr data           busy    rdy stl hld
        vecs[0]  = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     0,0,0,             'h0,    1,0,0);
        vecs[1]  = mk(1,5,'h12345678,  0,0,0,             0,0,   0,0,0,     0,0,0,             'h0,    1,0,0);
        vecs[2]  = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     1,5,'h12345678,    'h0,    1,0,0);
        vecs[3]  = mk(1,0,'hDEAD,      0,0,0,             0,0,   0,0,0,     0,5,'h12345678,    'h0,    1,0,0);
        vecs[4]  = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     0,5,'h12345678,    'h0,    1,0,0);
        vecs[5]  = mk(0,0,0,           0,0,0,             1,7,   0,0,0,     0,5,'h12345678,    'h0,    1,0,0);
        vecs[6]  = mk(0,0,0,           0,0,0,             0,0,   7,0,0,     0,5,'h12345678,    'h80,   1,1,0);
        vecs[7]  = mk(0,0,0,           1,7,'hCAFE,        0,0,   7,0,0,     0,5,'h12345678,    'h80,   1,1,0);
        vecs[8]  = mk(0,0,0,           0,0,0,             0,0,   0,7,0,     0,5,'h12345678,    'h80,   1,1,0);
        vecs[9]  = mk(0,0,0,           0,0,0,             0,0,   7,7,7,     1,7,'hCAFE,        'h0,    1,0,0);
        vecs[10] = mk(1,1,'h11,        1,2,'h22,          0,0,   0,0,0,     0,7,'hCAFE,        'h0,    1,0,0);
        vecs[11] = mk(1,1,'h12,        1,3,'h33,          0,0,   0,0,0,     1,1,'h11,          'h0,    1,0,0);
        vecs[12] = mk(1,1,'h13,        0,0,0,             0,0,   0,0,0,     1,1,'h12,          'h0,    0,1,1);
        vecs[13] = mk(1,1,'h13,        0,0,0,             0,0,   0,0,0,     1,2,'h22,          'h0,    1,0,0);
        vecs[14] = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     1,1,'h13,          'h0,    1,0,0);
        vecs[15] = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     1,3,'h33,          'h0,    1,0,0);
        vecs[16] = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     0,3,'h33,          'h0,    1,0,0);
        vecs[17] = mk(0,0,0,           0,0,0,             1,4,   0,0,0,     0,3,'h33,          'h0,    1,0,0);
        vecs[18] = mk(0,0,0,           1,4,'h44,          0,0,   0,0,0,     0,3,'h33,          'h10,   1,0,0);
        vecs[19] = mk(0,0,0,           0,0,0,             1,4,   0,0,0,     0,3,'h33,          'h10,   1,0,0);
        vecs[20] = mk(0,0,0,           0,0,0,             0,0,   0,0,4,     1,4,'h44,          'h10,   1,1,0);
        vecs[21] = mk(0,0,0,           1,4,'h45,          0,0,   0,0,0,     0,4,'h44,          'h10,   1,0,0);
        vecs[22] = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     0,4,'h44,          'h10,   1,0,0);
        vecs[23] = mk(0,0,0,           0,0,0,             0,0,   0,0,4,     1,4,'h45,          'h0,    1,0,0);
        vecs[24] = mk(0,0,0,           1,0,'h99,          1,0,   0,0,0,     0,4,'h45,          'h0,    1,0,0);
        vecs[25] = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     0,4,'h45,          'h0,    1,0,0);
        vecs[26] = mk(0,0,0,           0,0,0,             0,0,   0,0,0,     0,4,'h45,          'h0,    1,0,0);

        RESET = 1'b1;
        idle();
        repeat (3) @(negedge CLK);
        #1;
        check_row("reset", mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0, 'h0, 0,0,0));
        @(negedge CLK);
        RESET = 1'b0;

        for (int i = 0; i < NV; i++) begin
            if (i != 0) @(negedge CLK);
            drive(vecs[i]);
            #1;
            check_row($sformatf("row%0d", i), vecs[i]);
        end

        // Reset asserted while two FIFO entries are pending and x2/x3 are busy.
        @(negedge CLK); idle(); ISSUE_VALID = 1; ISSUE_RD = 2;
        @(negedge CLK); ISSUE_RD = 3;
        @(negedge CLK); idle(); ALU_VALID = 1; ALU_RD = 1; ALU_DATA = 'h55;
                        MD_VALID = 1; MD_RD = 2; MD_DATA = 'h66;
        @(negedge CLK); ALU_DATA = 'h56; MD_RD = 3; MD_DATA = 'h77;
        @(negedge CLK); ALU_DATA = 'h57; MD_VALID = 0;
        #1;
        check("pre-reset busy",  BUSY_MASK, 32'h0000_000C);
        check("pre-reset ready", {31'd0, MD_READY}, 32'd0);
        check("pre-reset hold",  {31'd0, ALU_HOLD}, 32'd1);
        check("pre-reset we",    {31'd0, WRITE_ENABLE}, 32'd1);
        #1 RESET = 1'b1;
        #1;
        check("mid-reset we",    {31'd0, WRITE_ENABLE}, 32'd0);
        check("mid-reset busy",  BUSY_MASK, 32'd0);
        check("mid-reset ready", {31'd0, MD_READY}, 32'd0);
        check("mid-reset addr",  {27'd0, WB_ADDRESS}, 32'd0);
        check("mid-reset data",  WRITE_DATA, 32'd0);
        @(negedge CLK);
        idle();
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            #1;
            check($sformatf("post-reset%0d we", k),    {31'd0, WRITE_ENABLE}, 32'd0);
            check($sformatf("post-reset%0d ready", k), {31'd0, MD_READY}, 32'd1);
            check($sformatf("post-reset%0d busy", k),  BUSY_MASK, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/regfile_writeback_ctrl.md
# regfile_writeback_ctrl

Write-side controller for the CPU register file: merges single-cycle ALU results and multi-cycle MUL/DIV (M-extension) results onto the register file's single write port (WB_ADDRESS / WRITE_ENABLE / WRITE_DATA). It buffers MUL/DIV results in a small FIFO and keeps a per-register busy scoreboard for in-flight MUL/DIV destinations. From the scoreboard it drives a STALL signal for the decode stage. Writes to x0 are never issued.

## Interface
Parameters:
- DATA_WIDTH, 32, register data width
- ADDR_WIDTH, 5, register address width (32 registers)
- FIFO_DEPTH, 2, MUL/DIV result buffer entries (power of 2, ≥2)

Ports:
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high
- ALU_VALID  in  1  ALU result present this cycle
- ALU_RD  in  ADDR_WIDTH  ALU destination register
- ALU_DATA  in  DATA_WIDTH  ALU result
- MD_VALID  in  1  MUL/DIV result offered
- MD_RD  in  ADDR_WIDTH  MUL/DIV destination
- MD_DATA  in  DATA_WIDTH  MUL/DIV result
- MD_READY  out  1  result accepted when MD_VALID && MD_READY
- ISSUE_VALID  in  1  MUL/DIV instruction issued this cycle
- ISSUE_RD  in  ADDR_WIDTH  destination of issued MUL/DIV
- CHK_RS1, CHK_RS2, CHK_RD  in  ADDR_WIDTH each  decode-stage operands to check
- STALL  out  1  decode must hold
- ALU_HOLD  out  1  ALU result refused this cycle; pipeline re-presents it
- WB_ADDRESS  out  ADDR_WIDTH  register file write address
- WRITE_ENABLE  out  1  register file write enable
- WRITE_DATA  out  DATA_WIDTH  register file write data
- BUSY_MASK  out  32  scoreboard, bit i = xi pending

## Operation
- Write-port source select, evaluated every cycle:
  - FIFO full (count == FIFO_DEPTH): FIFO head wins; ALU_HOLD = 1.
  - Otherwise, ALU_VALID && ALU_RD != 0: ALU wins.
  - Otherwise, FIFO non-empty: FIFO head wins.
  - Otherwise: no write.
- The selected source is registered into WB_ADDRESS / WRITE_DATA, with WRITE_ENABLE = 1, at the next edge. With no source, WRITE_ENABLE = 0 and address/data hold their last values.
- ALU_VALID with ALU_RD = 0 produces no write and does not block a FIFO drain that cycle.
- ALU_HOLD = ALU_VALID && FIFO full (combinational).
- MD_READY = !RESET && count < FIFO_DEPTH, computed from the registered count. A dequeue in the same cycle does not make a full FIFO ready.
- An accepted MD result with MD_RD = 0 is discarded and not enqueued. Otherwise {MD_RD, MD_DATA} is enqueued at the tail.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Scoreboard updates:
  - Set: ISSUE_VALID && ISSUE_RD != 0 sets BUSY_MASK[ISSUE_RD] at the edge.
  - Clear: a FIFO entry selected for write clears BUSY_MASK[rd] at the same edge.
  - Set and clear on the same rd at the same edge: set wins.
  - BUSY_MASK[0] is constant 0.
- STALL = ALU_HOLD | BUSY_MASK[CHK_RS1] | BUSY_MASK[CHK_RS2] | BUSY_MASK[CHK_RD] (combinational).
- An ALU write to a busy rd is still performed and does not clear the busy bit. The stall logic is responsible for preventing this case.
- Reset (asynchronous, at any time including mid-drain): FIFO emptied, pointers and count = 0, BUSY_MASK = 0, WB_ADDRESS = 0, WRITE_DATA = 0, WRITE_ENABLE = 0. MD_READY = 0 while RESET is high. STALL = 0 and ALU_HOLD = 0 unless driven by inputs.

## Timing
- ALU result: ALU_VALID in cycle N → WRITE_ENABLE high in cycle N+1 (1-cycle latency).
- MD result: accepted at edge N → earliest write in cycle N+2. The FIFO has no bypass path.
- Scoreboard: a set at edge N is visible in STALL during cycle N+1. A clear coincides with WRITE_ENABLE rising for that entry.
- Throughput: one register write per cycle. The FIFO drains only in cycles without an ALU write, or unconditionally when full.
- MD_READY, STALL and ALU_HOLD are combinational from registered state and current inputs. There are no combinational paths from MD_VALID to MD_READY.

## Test plan
- Reset then ALU_VALID=1, ALU_RD=5, ALU_DATA=0x12345678 → next cycle WRITE_ENABLE=1, WB_ADDRESS=5, WRITE_DATA=0x12345678. ALU_RD=0 in the same scenario → WRITE_ENABLE stays 0.
- ISSUE_VALID, ISSUE_RD=7; then CHK_RS1=7 → STALL=1, BUSY_MASK=0x80. Then MD result rd=7, data=0xCAFE with ALU idle → write of x7=0xCAFE two cycles after acceptance, BUSY_MASK=0, STALL=0.
- ALU_VALID every cycle (rd=1) while two MD results arrive (rd=2, rd=3):
  - FIFO fills, so MD_READY=0 and ALU_HOLD=1.
  - Next write is x2, then x3 in FIFO order.
  - ALU writes resume once count < FIFO_DEPTH.
- Same edge: FIFO entry rd=4 is written while ISSUE_VALID with ISSUE_RD=4 → BUSY_MASK[4] remains 1.
- MD result with MD_RD=0 accepted → no enqueue, count unchanged, no write.
- RESET asserted with FIFO holding 2 entries and BUSY_MASK=0x0C → immediately WRITE_ENABLE=0 and BUSY_MASK=0. After release, no pending writes are emitted and MD_READY=1.
